seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a shared 7-segment decoder driving N_DIG common-anode digits.

---
 rtl/seg7_scan_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for N_DIG common-anode 7-segment digits
// sharing one segment bus. A slot counter gives each digit DIV clock cycles.
// The first GAP cycles of every slot are blanked so the previous digit's
// segments do not ghost onto the next anode. The display value is
// double-buffered: writes land in a shadow buffer, and the shadow is copied
// into the active buffer only at the frame boundary, so a frame never tears.
//
// Optional feature macro: SEG7_LZB_EN
//   defined   -> leading-zero blanking on the active buffer (digit 0 always
//                shown, DP still follows iDP, anode timing unchanged)
//   undefined -> every digit is decoded, including leading zeros
//
// Ports
//   iCLK    in   1        system clock
//   iRST_N  in   1        asynchronous active-low reset
//   iVAL    in   4*N_DIG  display value, nibble k -> digit k (digit 0 = LSD)
//   iDP     in   N_DIG    decimal point per digit, 1 = lit
//   iWE     in   1        write strobe, captures iVAL/iDP into the shadow
//   iBLANK  in   1        level, forces all anodes off; scanning continues
//   oSEG    out  8        segments, active-low, {dp,g,f,e,d,c,b,a}
//   oDIG_N  out  N_DIG    anode enables, active-low, at most one low
//   oFRAME  out  1        pulse on the last cycle of digit N_DIG-1's slot
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
   parameter int N_DIG = 8,
   parameter int DIV   = 50000,
   parameter int GAP   = 16
) (
   input  logic               iCLK,
   input  logic               iRST_N,
   input  logic [4*N_DIG-1:0] iVAL,
   input  logic [N_DIG-1:0]   iDP,
   input  logic               iWE,
   input  logic               iBLANK,
   output logic [7:0]         oSEG,
   output logic [N_DIG-1:0]   oDIG_N,
   output logic               oFRAME
);

   localparam int CW = $clog2(DIV);
   localparam int IW = $clog2(N_DIG);

   typedef enum logic {
      GAPST,
      SHOW
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [4*N_DIG-1:0] shadow_val_q, shadow_val_d;
   logic [N_DIG-1:0]   shadow_dp_q, shadow_dp_d;
   logic [4*N_DIG-1:0] active_val_q, active_val_d;
   logic [N_DIG-1:0]   active_dp_q, active_dp_d;
   logic [7:0]         seg_q, seg_d;
   logic [N_DIG-1:0]   dig_q, dig_d;
   logic               frame_q, frame_d;

   logic               cnt_wrap;
   logic               last_dig;
   logic               swap;
   logic [3:0]         cur_nib;
   logic               cur_dp;
   logic [N_DIG-1:0]   cur_dig_n;
   logic               cur_lz;

   // Segment patterns for bits 6:0 (g..a), active-low.
   function automatic logic [6:0] decode7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h18;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // Slot counter, digit index and buffer swap. The swap happens on the very
   // cycle the last digit's slot wraps, and it copies the shadow as it stood
   // before that edge, so a write on the same cycle lands in the next frame.
   always_comb begin
      cnt_wrap     = (cnt_q == CW'(DIV - 1));
      last_dig     = (idx_q == IW'(N_DIG - 1));
      swap         = cnt_wrap && last_dig;

      cnt_d        = cnt_wrap ? '0 : cnt_q + 1'b1;
      idx_d        = idx_q;
      if (cnt_wrap) begin
         idx_d = last_dig ? '0 : idx_q + 1'b1;
      end

      shadow_val_d = iWE ? iVAL : shadow_val_q;
      shadow_dp_d  = iWE ? iDP  : shadow_dp_q;
      active_val_d = swap ? shadow_val_q : active_val_q;
      active_dp_d  = swap ? shadow_dp_q  : active_dp_q;
   end

   // Per-slot FSM: the anode stays off during the first GAP cycles.
   always_comb begin
      state_d = state_q;
      case (state_q)
         GAPST: if (cnt_q == CW'(GAP - 1)) state_d = SHOW;
         SHOW:  if (cnt_wrap)              state_d = GAPST;
         default: state_d = GAPST;
      endcase
   end

   // Select the current digit's nibble, DP and anode bit. The leading-zero
   // flag is a running AND from the top digit down: digit k is a leading
   // zero when it and every digit above it are zero.
   always_comb begin
      logic run;
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_dig_n = '1;
      cur_lz    = 1'b0;
      run       = 1'b1;
      for (int k = N_DIG - 1; k >= 0; k--) begin
         run = run && (active_val_q[4*k +: 4] == 4'h0);
         if (idx_q == IW'(k)) begin
            cur_nib      = active_val_q[4*k +: 4];
            cur_dp       = active_dp_q[k];
            cur_dig_n[k] = 1'b0;
            cur_lz       = run && (k != 0);
         end
      end
   end

   // Registered outputs, computed from the current counter/FSM state.
   always_comb begin
      seg_d   = 8'hFF;
      dig_d   = '1;
      frame_d = swap;
      if (!iBLANK && (state_q == SHOW)) begin
         dig_d = cur_dig_n;
`ifdef SEG7_LZB_EN
         seg_d = {~cur_dp, cur_lz ? 7'h7F : decode7(cur_nib)};
`else
         seg_d = {~cur_dp, decode7(cur_nib)};
`endif
      end
   end

`ifndef SEG7_LZB_EN
   // Without blanking the leading-zero flag has no consumer.
   logic unused_lz;
   assign unused_lz = cur_lz;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q      <= GAPST;
         cnt_q        <= '0;
         idx_q        <= '0;
         shadow_val_q <= '0;
         shadow_dp_q  <= '0;
         active_val_q <= '0;
         active_dp_q  <= '0;
         seg_q        <= 8'hFF;
         dig_q        <= '1;
         frame_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q  <= shadow_dp_d;
         active_val_q <= active_val_d;
         active_dp_q  <= active_dp_d;
         seg_q        <= seg_d;
         dig_q        <= dig_d;
         frame_q      <= frame_d;
      end
   end

   assign oSEG   = seg_q;
   assign oDIG_N = dig_q;
   assign oFRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Directed bench for seg7_scan_ctrl with N_DIG=4, DIV=8, GAP=2. A frame is
// 32 cycles. The bench counts clock edges since reset release; the output
// sampled after edge p reflects scan position s = (p-1) mod 32, digit s/8,
// slot count s%8, anode on when the count is 2 or more, oFRAME at s = 31.
// Expected segment bytes per digit are packed {d3,d2,d1,d0}.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

   logic        iCLK;
   logic        iRST_N;
   logic [15:0] iVAL;
   logic [3:0]  iDP;
   logic        iWE;
   logic        iBLANK;
   logic [7:0]  oSEG;
   logic [3:0]  oDIG_N;
   logic        oFRAME;

   int tests;
   int fails;
   int edges;

   seg7_scan_ctrl #(
      .N_DIG(4),
      .DIV  (8),
      .GAP  (2)
   ) dut (
      .iCLK  (iCLK),
      .iRST_N(iRST_N),
      .iVAL  (iVAL),
      .iDP   (iDP),
      .iWE   (iWE),
      .iBLANK(iBLANK),
      .oSEG  (oSEG),
      .oDIG_N(oDIG_N),
      .oFRAME(oFRAME)
   );

   // Clock: 10 time-unit period.
   initial iCLK = 1'b0;
   always #5 iCLK = ~iCLK;

   // Edges since reset release, used to locate the scan position.
   always @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) edges <= 0;
      else         edges <= edges + 1;
   end

   // Samples n cycles on the falling edge and compares against the scan
   // position. cur holds the active value; it switches to nxt after the
   // s = 31 sample, where the buffer swap takes effect.
   task automatic check_cycles(input int n, input logic [31:0] cur_in,
                               input logic [31:0] nxt_in, input logic blank,
                               input string name);
      logic [31:0] cur;
      logic [7:0]  exp_seg;
      logic [3:0]  exp_dig;
      logic        exp_frame;
      int          s;
      int          cnt;
      int          idx;
      cur = cur_in;
      for (int i = 0; i < n; i++) begin
         @(negedge iCLK);
         s         = (edges - 1) % 32;
         cnt       = s % 8;
         idx       = s / 8;
         exp_frame = (s == 31);
         exp_seg   = 8'hFF;
         exp_dig   = 4'hF;
         if (!blank && cnt >= 2) begin
            exp_seg      = cur[8*idx +: 8];
            exp_dig[idx] = 1'b0;
         end
         tests++;
         if (oDIG_N !== exp_dig) begin
            fails++;
            $display("[TB] FAIL %s dig s=%0d: got %b expected %b", name, s, oDIG_N, exp_dig);
         end
         tests++;
         if (oSEG !== exp_seg) begin
            fails++;
            $display("[TB] FAIL %s seg s=%0d: got %h expected %h", name, s, oSEG, exp_seg);
         end
         tests++;
         if (oFRAME !== exp_frame) begin
            fails++;
            $display("[TB] FAIL %s frame s=%0d: got %b expected %b", name, s, oFRAME, exp_frame);
         end
         if (s == 31) cur = nxt_in;
      end
   endtask

   // Advances without checking until the sample at position target.
   task automatic go_to_phase(input int target);
      bit hit;
      hit = 0;
      for (int i = 0; i < 64 && !hit; i++) begin
         @(negedge iCLK);
         if ((edges - 1) % 32 == target) hit = 1;
      end
      if (!hit) begin
         tests++;
         fails++;
         $display("[TB] FAIL go_to_phase: got no hit expected position %0d", target);
      end
   endtask

   task automatic pulse_we(input logic [15:0] val, input logic [3:0] dp);
      iVAL = val;
      iDP  = dp;
      iWE  = 1'b1;
      @(negedge iCLK);
      iWE  = 1'b0;
   endtask

   task automatic test_reset;
      iRST_N = 1'b0;
      repeat (3) @(negedge iCLK);
      tests++;
      if (oSEG !== 8'hFF) begin
         fails++;
         $display("[TB] FAIL reset_seg: got %h expected ff", oSEG);
      end
      tests++;
      if (oDIG_N !== 4'hF) begin
         fails++;
         $display("[TB] FAIL reset_dig: got %b expected 1111", oDIG_N);
      end
      tests++;
      if (oFRAME !== 1'b0) begin
         fails++;
         $display("[TB] FAIL reset_frame: got %b expected 0", oFRAME);
      end
      iRST_N = 1'b1;
   endtask

   task automatic test_scan_default;
      check_cycles(64, 32'hC0C0C0C0, 32'hC0C0C0C0, 1'b0, "scan_default");
   endtask

   // 12AF with DP on digit 2: d3=F9 d2=24 d1=88 d0=8E.
   task automatic test_write;
      go_to_phase(10);
      iVAL = 16'h12AF;
      iDP  = 4'b0100;
      iWE  = 1'b1;
      check_cycles(1, 32'hC0C0C0C0, 32'hF924888E, 1'b0, "write_we");
      iWE  = 1'b0;
      check_cycles(53, 32'hC0C0C0C0, 32'hF924888E, 1'b0, "write_swap");
   endtask

   // 9876 written first; 5555 written on the swap cycle itself.
   task automatic test_back_to_back;
      go_to_phase(5);
      pulse_we(16'h9876, 4'b0000);
      go_to_phase(30);
      iVAL = 16'h5555;
      iDP  = 4'b0000;
      iWE  = 1'b1;
      check_cycles(1, 32'hF924888E, 32'h9880F882, 1'b0, "collide_edge");
      iWE  = 1'b0;
      check_cycles(32, 32'h9880F882, 32'h92929292, 1'b0, "collide_old");
      check_cycles(32, 32'h92929292, 32'h92929292, 1'b0, "collide_new");
   endtask

   task automatic test_blank;
      go_to_phase(3);
      iBLANK = 1'b1;
      check_cycles(20, 32'h92929292, 32'h92929292, 1'b1, "blank_on");
      iBLANK = 1'b0;
      check_cycles(20, 32'h92929292, 32'h92929292, 1'b0, "blank_off");
   endtask

   task automatic test_lzb;
      logic [31:0] exp70;
      logic [31:0] exp00;
`ifdef SEG7_LZB_EN
      exp70 = 32'hFFFFF8C0;
      exp00 = 32'hFFFFFFC0;
`else
      exp70 = 32'hC0C0F8C0;
      exp00 = 32'hC0C0C0C0;
`endif
      go_to_phase(8);
      pulse_we(16'h0070, 4'b0000);
      check_cycles(54, 32'h92929292, exp70, 1'b0, "lzb_0070");
      pulse_we(16'h0000, 4'b0000);
      check_cycles(54, exp70, exp00, 1'b0, "lzb_0000");
   endtask

   task automatic test_reset_mid;
      go_to_phase(8);
      pulse_we(16'h4321, 4'b1111);
      go_to_phase(12);
      iRST_N = 1'b0;
      #1;
      tests++;
      if (oSEG !== 8'hFF) begin
         fails++;
         $display("[TB] FAIL midreset_seg: got %h expected ff", oSEG);
      end
      tests++;
      if (oDIG_N !== 4'hF) begin
         fails++;
         $display("[TB] FAIL midreset_dig: got %b expected 1111", oDIG_N);
      end
      @(negedge iCLK);
      iRST_N = 1'b1;
      check_cycles(40, 32'hC0C0C0C0, 32'hC0C0C0C0, 1'b0, "midreset_restart");
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      iRST_N = 1'b0;
      iVAL   = '0;
      iDP    = '0;
      iWE    = 1'b0;
      iBLANK = 1'b0;
      test_reset();
      test_scan_default();
      test_write();
      test_back_to_back();
      test_blank();
      test_lzb();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
